// File: rtl/i2s_axis_packetizer.sv
// Buffers the push-only I2S word stream in a FIFO and re-emits it as an AXI4-Stream
// master, with tlast on every BULK_OF_DATA-th word and a sticky flag for dropped words.
module i2s_axis_packetizer #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BULK_OF_DATA         = 87,
  parameter int unsigned FIFO_DEPTH           = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wen,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     wdata,
  output logic                                m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic                                overflow,
  output logic [31:0]                         packet_count,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (BULK_OF_DATA > 1) ? $clog2(BULK_OF_DATA) : 1;
  localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;

  // Entry layout: {last, data}
  logic [DW:0]   mem_q [FIFO_DEPTH];

  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          tvalid_q, tvalid_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tlast_q, tlast_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;

  logic          full, empty, wr_en, rd_en, last_in, handshake;

  // Fullness uses the start-of-cycle level, so a same-cycle read never rescues a write.
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign wr_en     = wen & ~full;
  assign rd_en     = ~empty & (~tvalid_q | m_axis_tready);
  assign last_in   = (in_cnt_q == CW'(BULK_OF_DATA - 1));
  assign handshake = tvalid_q & m_axis_tready;

  always_comb begin
    in_cnt_d   = in_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(rd_en);
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    overflow_d = overflow_q | (wen & full);
    pkt_cnt_d  = pkt_cnt_q;

    // Framing counts every presented word, stored or dropped, to stay aligned upstream.
    if (wen) begin
      in_cnt_d = last_in ? '0 : in_cnt_q + CW'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      tvalid_d = 1'b1;
      tdata_d  = mem_q[rd_ptr_q][DW-1:0];
      tlast_d  = mem_q[rd_ptr_q][DW];
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
    if (handshake && tlast_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      in_cnt_q   <= in_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= {last_in, wdata};
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tstrb  = '1;
  assign overflow      = overflow_q;
  assign packet_count  = pkt_cnt_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_i2s_axis_packetizer.sv
// Randomised and directed bench for i2s_axis_packetizer, checked against a queue-based
// reference model of the buffering, framing and drop rules.
module tb_i2s_axis_packetizer;

  localparam int unsigned W     = 32;
  localparam int unsigned BULK  = 87;
  localparam int unsigned DEPTH = 256;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wen = 1'b0;
  logic [W-1:0]       wdata = '0;
  logic               tready = 1'b0;
  logic               tvalid;
  logic [W-1:0]       tdata;
  logic [W/8-1:0]     tstrb;
  logic               tlast;
  logic               ovf;
  logic [31:0]        pcount;
  logic [$clog2(DEPTH):0] level;

  i2s_axis_packetizer #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .BULK_OF_DATA        (BULK),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .wdata        (wdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tdata (tdata),
    .m_axis_tstrb (tstrb),
    .m_axis_tlast (tlast),
    .m_axis_tready(tready),
    .overflow     (ovf),
    .packet_count (pcount),
    .fifo_level   (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: accepted words queue, one-entry output slot, counters.
  logic [W:0]   mq[$];
  bit           mvalid;
  logic [W-1:0] mdata;
  bit           mlast;
  bit           movf;
  int unsigned  mpc;
  int unsigned  mcnt;
  int           beats;
  int           tlast_at[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mvalid = 0; mdata = '0; mlast = 0; movf = 0;
    mpc = 0; mcnt = 0; beats = 0;
    tlast_at.delete();
  endtask

  task automatic model_edge();
    bit hs;
    bit was_full;
    bit load;
    hs       = mvalid && tready;
    was_full = (mq.size() >= DEPTH);
    if (hs) begin
      beats++;
      if (mlast) begin
        mpc++;
        tlast_at.push_back(beats);
      end
    end
    load = (mq.size() != 0) && (!mvalid || tready);
    if (load) begin
      {mlast, mdata} = mq.pop_front();
      mvalid = 1;
    end else if (hs) begin
      mvalid = 0;
    end
    if (wen) begin
      if (!was_full) mq.push_back({(mcnt == BULK - 1), wdata});
      else movf = 1;
      mcnt = (mcnt + 1) % BULK;
    end
  endtask

  task automatic compare_all();
    chk("tvalid", tvalid, mvalid);
    chk("fifo_level", level, mq.size());
    chk("overflow", ovf, movf);
    chk("packet_count", pcount, mpc);
    chk("tstrb", tstrb, {(W/8){1'b1}});
    if (mvalid) begin
      chk("tdata", tdata, mdata);
      chk("tlast", tlast, mlast);
    end
  endtask

  task automatic cyc(input bit w, input logic [W-1:0] d, input bit r);
    wen = w; wdata = d; tready = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 0; wen = 0; tready = 0;
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_packet_count", pcount, 0);
    chk("rst_fifo_level", level, 0);
    rst_n = 1;
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((mvalid || mq.size() != 0) && n < 4000) begin
      cyc(0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_timeout", (n < 4000), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    do_reset();

    // Single bulk, tready high
    cyc(1, 0, 1);
    chk("lat_edge1_tvalid", tvalid, 0);
    cyc(1, 1, 1);
    chk("lat_edge2_tvalid", tvalid, 1);
    chk("first_tdata", tdata, 0);
    for (int i = 2; i < 87; i++) cyc(1, W'(i), 1);
    drain(0);
    chk("single_beats", beats, 87);
    chk("single_nlast", tlast_at.size(), 1);
    chk("single_last_pos", (tlast_at.size() > 0) ? tlast_at[0] : -1, 87);
    chk("single_pc", pcount, 1);
    chk("single_ovf", ovf, 0);

    // Backpressure: two bulks with tready low
    do_reset();
    for (int i = 0; i < 174; i++) cyc(1, W'(i), 0);
    chk("bp_level", level, 173);
    chk("bp_tvalid", tvalid, 1);
    chk("bp_tdata", tdata, 0);
    drain(0);
    chk("bp_beats", beats, 174);
    chk("bp_nlast", tlast_at.size(), 2);
    chk("bp_last2", (tlast_at.size() > 1) ? tlast_at[1] : -1, 174);
    chk("bp_pc", pcount, 2);

    // Overflow, then read+write at full
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, W'(i), 0);
      if (i == 256) chk("ovf_before_drop", ovf, 0);
      if (i == 257) chk("ovf_after_drop", ovf, 1);
    end
    chk("ovf_level", level, 256);
    cyc(1, 32'h999, 1);
    chk("full_rw_level", level, 255);
    chk("full_rw_ovf", ovf, 1);
    drain(0);
    chk("ovf_beats", beats, 257);
    chk("ovf_nlast", tlast_at.size(), 2);
    chk("ovf_last1", (tlast_at.size() > 0) ? tlast_at[0] : -1, 87);
    chk("ovf_pc", pcount, 2);

    // Random tready with random wen gaps
    do_reset();
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 87; k++) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) cyc(0, '0, 1'($urandom_range(0, 1)));
        cyc(1, $urandom, 1'($urandom_range(0, 1)));
      end
    end
    drain(1);
    chk("rnd_beats", beats, 870);
    chk("rnd_pc", pcount, 10);
    chk("rnd_ovf", ovf, 0);

    // Reset mid-packet
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1, W'(1000 + i), 0);
    do_reset();
    for (int i = 0; i < 87; i++) cyc(1, W'(i), 1);
    drain(0);
    chk("mid_beats", beats, 87);
    chk("mid_nlast", tlast_at.size(), 1);
    chk("mid_last_pos", (tlast_at.size() > 0) ? tlast_at[0] : -1, 87);
    chk("mid_pc", pcount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_axis_packetizer.md
# i2s_axis_packetizer

Sits directly downstream of the multi-channel I2S receiver wrapper. It accepts that wrapper's push-only word stream (`wen`/`wdata`, no backpressure) and buffers it in an internal FIFO. It re-emits the words as an AXI4-Stream master towards the DMA, with `tlast` marking each `BULK_OF_DATA`-word bulk. Overflow is detected and flagged because the upstream cannot be stalled.

## Interface
Parameters:
- `C_M_AXIS_TDATA_WIDTH`, 32: data width; equals upstream `wdata` width.
- `BULK_OF_DATA`, 87: words per packet; must match the upstream wrapper's bulk size; ≥ 2.
- `FIFO_DEPTH`, 256: FIFO entries, power of two, ≥ 2·`BULK_OF_DATA`.

Ports:
- `clk`, in, 1: clock. The upstream `wclk` is driven from this same clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `wen`, in, 1: one word presented this cycle.
- `wdata`, in, `C_M_AXIS_TDATA_WIDTH`: word data, valid when `wen`=1.
- `m_axis_tvalid`, out, 1: AXIS valid.
- `m_axis_tdata`, out, `C_M_AXIS_TDATA_WIDTH`: AXIS data.
- `m_axis_tstrb`, out, `C_M_AXIS_TDATA_WIDTH/8`: constant all-ones.
- `m_axis_tlast`, out, 1: last word of a bulk.
- `m_axis_tready`, in, 1: AXIS ready.
- `overflow`, out, 1: sticky; at least one word has been dropped.
- `packet_count`, out, 32: packets completed on AXIS.
- `fifo_level`, out, clog2(`FIFO_DEPTH`)+1: FIFO occupancy; excludes the output register.

## Operation
- **Ingress counter `in_cnt`** (0..`BULK_OF_DATA`-1): advances on every `wen`, whether the word is stored or dropped. It wraps to 0 after `BULK_OF_DATA`-1. Framing therefore stays aligned to the upstream bulks.
- **FIFO entry:** {last, data}. last = (`in_cnt` == `BULK_OF_DATA`-1) at write time.
- **Write:** if `wen` and `fifo_level` < `FIFO_DEPTH`, the entry is stored.
- **Drop:** if `wen` and the FIFO is full, the word is discarded and `overflow` is set.
  - Fullness is judged on the start-of-cycle level. A read in the same cycle does not rescue the write.
- **Merged packets after a drop:** a dropped word that carried last is lost. The surviving words of that bulk then merge with the next packet. This is the defined behaviour; `overflow` flags it.
- **Output register** holds {tlast, tdata} and drives `m_axis_tvalid`.
  - It loads from the FIFO head when the FIFO is non-empty and (`m_axis_tvalid`=0 or `m_axis_tready`=1).
  - Otherwise it holds while `tvalid`=1 and `tready`=0 (AXIS stability rule: data, last and valid do not change).
- **`tvalid` deasserts** after a handshake if the FIFO is empty.
- **`packet_count`** increments on `tvalid`·`tready`·`tlast`; wraps modulo 2^32.
- **`overflow`** is cleared only by reset.
- **Total buffering** = `FIFO_DEPTH` + 1, including the output register.

## Timing
- **Reset values** (`rst_n`=0 at a `clk` edge):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `overflow`=0, `packet_count`=0, `fifo_level`=0.
  - Internally: `in_cnt`=0 and both pointers=0.
  - Reset mid-packet discards all buffered words. The next `wen` starts a new packet.
- **Latency:** `wen` at edge N → entry in FIFO after edge N+1 → `m_axis_tvalid`=1 after edge N+2, when the output register is empty.
- **Throughput:** one beat per cycle sustained while `tready`=1.
- **`fifo_level`** updates by +1 (write), -1 (read), 0 (both or neither) each cycle.
- **`wen` is accepted every cycle**, back-to-back, with no gap requirement.

## Test plan
- **Single bulk:** 87 consecutive `wen` with `wdata`=0..86, `tready`=1.
  - 87 beats in order; `tlast` only on data 86.
  - First `tvalid` 2 cycles after the first `wen`.
  - `packet_count`=1, `overflow`=0.
- **Backpressure:** `tready`=0 while 174 words are written.
  - `tvalid`=1 and `tdata` holds word 0 stably.
  - `fifo_level`=173, `overflow`=0.
  - Raise `tready`: 174 beats in order, `tlast` on beats 87 and 174, `packet_count`=2.
- **Overflow:** `tready`=0 while 300 words are written.
  - Words 0..256 retained, words 257..299 dropped.
  - `overflow`=1 from the cycle after word 257. `fifo_level`=256.
  - Drain: 257 beats; `tlast` on beats 87, 174 and 261-mapped indices only where stored (beats 87 and 174).
- **Simultaneous read/write at full:** FIFO full, one-cycle `tready`=1 with `wen`=1.
  - Incoming word dropped, `overflow`=1, `fifo_level`=255.
- **Random `tready`:** 50 % random `tready`, 10 bulks written with random `wen` gaps.
  - No `tvalid`/`tdata` change while stalled.
  - 870 beats in order, `packet_count`=10.
- **Reset mid-packet:** reset after 40 words of a bulk.
  - All outputs return to reset values.
  - The next 87 words form one packet with `tlast` on the 87th.
